lsu_mem_stage: RTL

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. It takes the EX/MEM access controls (read/write, address, store data, func3) and drives a word-organised data memory over a req/ack handshake. It performs byte-lane steering and load sign/zero extension. It stalls the pipeline until the access completes, so data memory may have variable latency.

---
 rtl/lsu_mem_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit with byte-lane steering, load extension and a req/ack stall handshake.
// Optional misaligned-access rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_mem_stage #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  stall,
  output logic                  misalign,
  output logic                  timeout_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DM_ADDRESS-1:0] m_addr,
  output logic [3:0]            m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  // Count value during the last REQ cycle allowed before giving up.
  localparam logic [TIMEOUT_W-1:0] LAST_REQ = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state, state_next;
  logic [TIMEOUT_W-1:0] req_count;
  logic [2:0]           func3_q;
  logic [1:0]           lane_q;
  logic                 access, is_byte, is_half, misaligned, req_last;
  logic [3:0]           be_in;
  logic [4:0]           shift_bits;
  logic [DATA_W-1:0]    wdata_in, rdata_shift, load_ext;

  assign access   = mem_read | mem_write;
  assign is_byte  = (func3[1:0] == 2'b00);
  assign is_half  = (func3[1:0] == 2'b01);
  assign req_last = (req_count == LAST_REQ);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = wr_data;
    if (is_byte) begin
      be_in    = 4'b0001 << addr[1:0];
      wdata_in = {4{wr_data[7:0]}};
    end else if (is_half) begin
      be_in    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{wr_data[15:0]}};
    end
  end

  // Move the addressed lane of the returned word down to bit 0, then extend.
  always_comb begin
    case (func3_q[1:0])
      2'b00:   shift_bits = {lane_q, 3'b000};
      2'b01:   shift_bits = {lane_q[1], 4'b0000};
      default: shift_bits = 5'd0;
    endcase
    rdata_shift = m_rdata >> shift_bits;
    case (func3_q)
      3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
      3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b101:  load_ext = {16'd0, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    m_req      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall      = 1'b1;
          state_next = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        m_req = 1'b1;
        if (m_ack || req_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_count   <= '0;
      func3_q     <= 3'd0;
      lane_q      <= 2'd0;
      rd_data     <= '0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_be        <= 4'd0;
      m_wdata     <= '0;
    end else begin
      state    <= state_next;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            m_we      <= mem_write;
            m_addr    <= {addr[DM_ADDRESS-1:2], 2'b00};
            m_be      <= be_in;
            m_wdata   <= wdata_in;
            func3_q   <= func3;
            lane_q    <= addr[1:0];
            req_count <= '0;
            if (misaligned) begin
              misalign <= 1'b1;
              rd_data  <= '0;
            end
          end
        end
        REQ: begin
          if (m_ack) begin
            rd_data <= load_ext;
          end else begin
            req_count <= req_count + 1'b1;
            if (req_last) begin
              timeout_err <= 1'b1;
              rd_data     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
